countdown_gen: RTL
==================

Name: countdown_gen

Overview:
- Parametrised countdown sequencer for the arbiter game front-end.
- Lights a bar of N_LEDS LEDs, which blink (or stay steady) at the tick rate. One LED is extinguished every TICKS_PER_STEP ticks, from MSB down to LSB.
- Flags completion to the game FSM.
- Adds start/abort/pause control, a remaining-step count and a done pulse, so the game can re-arm without a reset.

Parameters:
- CLOCK_FREQ, 12000000, system clock frequency in Hz.
- PRESCALER_COUNT, CLOCK_FREQ/4, clk cycles per tick. Must be >= 2.
- N_LEDS, 4, number of countdown LEDs. Must be >= 1.
- TICKS_PER_STEP, 8, ticks per extinguished LED. Must be >= 1.
- BLINK, 1, selects LED mode. 1 = lit LEDs toggle every tick; 0 = lit LEDs steady on.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_in  in  1  level-sampled; starts a countdown from IDLE or DONE.
- abort_in  in  1  returns the block to IDLE from any state; has priority over all other inputs.
- pause_in  in  1  level; freezes the countdown while high.
- leds_out  out  N_LEDS  LED drive (registered).
- busy_out  out  1  high in RUN or PAUSED.
- cd_done_out  out  1  level, high while in DONE.
- done_pulse_out  out  1  single-cycle pulse on entry to DONE.
- remaining_out  out  $clog2(N_LEDS+1)  number of LEDs still in the countdown mask.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; all outputs 0; prescaler, step counter and blink phase 0; mask all 0.
- States: IDLE, RUN, PAUSED, DONE. All transitions occur on the rising clk edge.
- Transition priority, highest first: abort_in, then start_in, then pause_in.
- IDLE -> RUN on start_in. On that edge:
  - mask <= all 1s; remaining_out <= N_LEDS.
  - prescaler, step counter and phase <= 0.
  - busy_out <= 1.
- RUN -> PAUSED when pause_in is high. PAUSED -> RUN when pause_in is low.
- In PAUSED, prescaler, step counter, phase, mask and leds_out are all frozen.
- start_in in RUN or PAUSED is ignored; there is no restart mid-count.
- Prescaler: counts 0..PRESCALER_COUNT-1 only in RUN, then wraps. tick = 1 in the RUN cycle where prescaler == PRESCALER_COUNT-1.
- On each tick:
  - phase toggles.
  - Step counter increments, wrapping at TICKS_PER_STEP-1.
  - On wrap, mask <= mask >> 1 (shifting in 0) and remaining_out decrements.
- Final step: when a wrap occurs with mask == 1, state <= DONE on the same edge. Also on that edge:
  - cd_done_out <= 1; done_pulse_out <= 1 for exactly one cycle.
  - busy_out <= 0; remaining_out <= 0; leds_out <= 0.
- Total time: exactly N_LEDS*TICKS_PER_STEP*PRESCALER_COUNT RUN cycles, counted from the start edge to the DONE edge. PAUSED cycles are not counted.
- leds_out:
  - BLINK=1: registered as mask & {N_LEDS{~phase}}, evaluated with next-state values. This means all mask LEDs are on in the first RUN cycle, and toggle each tick.
  - BLINK=0: leds_out = mask.
  - leds_out = 0 in IDLE and DONE.
- DONE holds until start_in or abort_in.
  - DONE + start_in: behaves exactly as IDLE + start_in; cd_done_out <= 0 on the same edge.
  - DONE + abort_in: goes to IDLE; cd_done_out <= 0.
- abort_in, any state: on the next edge, state <= IDLE and every output and internal counter returns to its reset value. abort_in + start_in on the same edge -> IDLE.
- Widths:
  - Prescaler: $clog2(PRESCALER_COUNT) bits.
  - Step counter: max(1, $clog2(TICKS_PER_STEP)) bits.
  - All counters compare with >= on the terminal value, so a corrupted count self-recovers.
- No combinational path from any input to any output.

Test Plan (PRESCALER_COUNT=4, TICKS_PER_STEP=2, N_LEDS=4, BLINK=1 unless noted):
- Reset, then start_in pulsed 1 cycle:
  - Next cycle: busy_out=1, leds_out=4'b1111, remaining_out=4.
  - leds_out toggles every 4 cycles.
  - leds_out MSB is dark after 8 cycles; remaining_out=3.
  - cd_done_out rises, and done_pulse_out=1 for 1 cycle, exactly 32 cycles after the start edge; leds_out=0.
- pause_in high for 10 cycles mid-run: leds_out and remaining_out are frozen throughout; DONE is reached at 42 cycles instead of 32.
- abort_in asserted at cycle 13 of a run: next cycle all outputs are 0 and state is IDLE. A following start_in gives a full 32-cycle run.
- start_in and abort_in high together in IDLE: stays IDLE. start_in alone while in RUN: timing unchanged (DONE still at 32).
- In DONE, assert start_in: cd_done_out drops on the same edge and leds_out=4'b1111; a new 32-cycle run completes.
- BLINK=0, N_LEDS=1, TICKS_PER_STEP=1: leds_out=1 steady for 4 cycles, then DONE. Assert reset_n low asynchronously mid-run: outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/countdown_gen.sv
// Countdown sequencer: lights an LED bar and extinguishes one LED per step, MSB first, then flags done.
// Latency: every output is registered; inputs sampled on a rising clk edge take effect on that edge.
// Backpressure: none; pause_in freezes the count, abort_in returns to IDLE with top priority.
module countdown_gen #(
    parameter int CLOCK_FREQ      = 12000000,
    parameter int PRESCALER_COUNT = CLOCK_FREQ / 4,
    parameter int N_LEDS          = 4,
    parameter int TICKS_PER_STEP  = 8,
    parameter int BLINK           = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic                        pause_in,
    output logic [N_LEDS-1:0]           leds_out,
    output logic                        busy_out,
    output logic                        cd_done_out,
    output logic                        done_pulse_out,
    output logic [$clog2(N_LEDS+1)-1:0] remaining_out
);

    localparam int PW = $clog2(PRESCALER_COUNT);
    localparam int SW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int RW = $clog2(N_LEDS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     psc_q, psc_d;
    logic [SW-1:0]     step_q, step_d;
    logic              phase_q, phase_d;
    logic [N_LEDS-1:0] mask_q, mask_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pulse_q, pulse_d;
    logic              tick;
    logic              wrap;

    // State and counter registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            psc_q   <= '0;
            step_q  <= '0;
            phase_q <= 1'b0;
            mask_q  <= '0;
            rem_q   <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state, counter and output computation; abort beats start beats pause.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        step_d  = step_q;
        phase_d = phase_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        pulse_d = 1'b0;
        leds_d  = '0;
        // >= on terminal values lets a corrupted counter fall back into range.
        tick    = (state_q == RUN) && (psc_q >= PW'(PRESCALER_COUNT - 1));
        wrap    = tick && (step_q >= SW'(TICKS_PER_STEP - 1));

        if (abort_in) begin
            state_d = IDLE;
            psc_d   = '0;
            step_d  = '0;
            phase_d = 1'b0;
            mask_d  = '0;
            rem_d   = '0;
        end else if (start_in && (state_q == IDLE || state_q == DONE)) begin
            state_d = RUN;
            psc_d   = '0;
            step_d  = '0;
            phase_d = 1'b0;
            mask_d  = {N_LEDS{1'b1}};
            rem_d   = RW'(N_LEDS);
        end else if (state_q == RUN) begin
            // A RUN cycle always counts, even the one that enters PAUSED.
            psc_d = tick ? '0 : psc_q + PW'(1);
            if (tick) begin
                phase_d = ~phase_q;
                step_d  = wrap ? '0 : step_q + SW'(1);
            end
            if (wrap) begin
                mask_d = mask_q >> 1;
                rem_d  = rem_q - RW'(1);
            end
            if (wrap && (mask_q == N_LEDS'(1))) begin
                state_d = DONE;
                pulse_d = 1'b1;
            end else if (pause_in) begin
                state_d = PAUSED;
            end
        end else if (state_q == PAUSED) begin
            if (!pause_in) begin
                state_d = RUN;
            end
        end

        busy_d = (state_d == RUN) || (state_d == PAUSED);
        done_d = (state_d == DONE);
        if (busy_d) begin
            if (BLINK != 0) begin
                leds_d = mask_d & {N_LEDS{~phase_d}};
            end else begin
                leds_d = mask_d;
            end
        end
    end

    assign leds_out       = leds_q;
    assign busy_out       = busy_q;
    assign cd_done_out    = done_q;
    assign done_pulse_out = pulse_q;
    assign remaining_out  = rem_q;

endmodule
